// File: rtl/gray_mem_arb.sv
// Two-client round-robin arbiter for the gray-image read port, with bounded bursts.
// Optional per-client accept counters are compiled in with ARB_STAT_EN.
module gray_mem_arb #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_BURST = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c0_req,
  input  logic [AW-1:0] c0_addr,
  output logic          c0_gnt,
  output logic          c0_rvalid,
  output logic [DW-1:0] c0_rdata,
  input  logic          c1_req,
  input  logic [AW-1:0] c1_addr,
  output logic          c1_gnt,
  output logic          c1_rvalid,
  output logic [DW-1:0] c1_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_data,
`ifdef ARB_STAT_EN
  input  logic          stat_clr,
  output logic [15:0]   c0_acc_cnt,
  output logic [15:0]   c1_acc_cnt,
`endif
  output logic [1:0]    dbg_state
);

  // Handshake: mem_req/mem_addr are offered to memory; a read is accepted on a
  // cycle where mem_req & mem_ready are both high, and the owning client sees
  // its gnt in that same cycle. Data returns exactly one cycle after accept.

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_C = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          own1;
  logic          own_req;
  logic          oth_req;
  logic [AW-1:0] own_addr;

  assign own1     = (state_q == OWN1);
  assign own_req  = own1 ? c1_req : c0_req;
  assign oth_req  = own1 ? c0_req : c1_req;
  assign own_addr = own1 ? c1_addr : c0_addr;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    c0_gnt   = 1'b0;
    c1_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // rr holds the last served client, so a tie goes to the other one.
        if (c0_req && (!c1_req || rr_q)) begin
          state_d = OWN0;
        end else if (c1_req) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        mem_req  = own_req;
        mem_addr = own_addr;
        c0_gnt   = !own1 && c0_req && mem_ready;
        c1_gnt   = own1 && c1_req && mem_ready;
        if (!own_req) begin
          cnt_d = '0;
          if (oth_req) begin
            state_d = own1 ? OWN0 : OWN1;
          end else begin
            state_d = IDLE;
          end
        end else if (mem_ready) begin
          rr_d = own1;
          if (cnt_q == LAST_C) begin
            // Burst limit only forces a handover when the other client waits.
            cnt_d = '0;
            if (oth_req) begin
              state_d = own1 ? OWN0 : OWN1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
    end else begin
      c0_rvalid <= c0_gnt;
      c1_rvalid <= c1_gnt;
    end
  end

  assign c0_rdata  = c0_rvalid ? mem_data : '0;
  assign c1_rdata  = c1_rvalid ? mem_data : '0;
  assign dbg_state = state_q;

`ifdef ARB_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c0_acc_cnt <= '0;
      c1_acc_cnt <= '0;
    end else if (stat_clr) begin
      c0_acc_cnt <= '0;
      c1_acc_cnt <= '0;
    end else begin
      if (c0_gnt && (c0_acc_cnt != 16'hFFFF)) c0_acc_cnt <= c0_acc_cnt + 16'd1;
      if (c1_gnt && (c1_acc_cnt != 16'hFFFF)) c1_acc_cnt <= c1_acc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_mem_arb.sv
// Randomised and directed bench for gray_mem_arb: cycle-level reference model of
// the arbitration rules plus a scoreboard queue for the returned read beats.
module tb_gray_mem_arb;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MB = 9;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          c0_req = 1'b0, c1_req = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [1:0]    dbg_state;
`ifdef ARB_STAT_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   c0_acc_cnt, c1_acc_cnt;
`endif

  gray_mem_arb #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(c0_gnt),
    .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_gnt(c1_gnt),
    .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
`ifdef ARB_STAT_EN
    .stat_clr(stat_clr), .c0_acc_cnt(c0_acc_cnt), .c1_acc_cnt(c1_acc_cnt),
`endif
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {client, data} per expected read beat
  logic [DW:0] exp_q[$];

  // reference model state: owner -1 = nobody
  int m_owner;
  int m_burst;
  int m_rr;

  // client / memory drivers
  logic          pend[2];
  logic [AW-1:0] paddr[2];
  int            prob[2];
  int            rdy_prob;
  bit            rdy_toggle;
  bit            rdy_phase;
  logic          last_acc;
  logic [AW-1:0] last_addr;
  int            gcode;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_burst  = 0;
    m_rr     = 1;
    exp_q.delete();
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_gnt"}, 32'({c0_gnt, c1_gnt}), 0);
    chk({tag, "_rvalid"}, 32'({c0_rvalid, c1_rvalid}), 0);
    chk({tag, "_rdata"}, 32'({c0_rdata, c1_rdata}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    c0_req    = 1'b0;
    c1_req    = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_all_zero("reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Compare this cycle's combinational outputs against the model, then advance it.
  task automatic eval_cycle();
    logic          r[2];
    logic [AW-1:0] a[2];
    logic          eg[2];
    logic          e_req;
    logic [AW-1:0] e_addr;
    int            x, y;
    r[0] = c0_req;  r[1] = c1_req;
    a[0] = c0_addr; a[1] = c1_addr;
    eg[0] = 1'b0;   eg[1] = 1'b0;
    e_req = 1'b0;   e_addr = '0;
    if (m_owner >= 0) begin
      x      = m_owner;
      e_req  = r[x];
      e_addr = a[x];
      eg[x]  = r[x] && mem_ready;
    end
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("c0_gnt", 32'(c0_gnt), 32'(eg[0]));
    chk("c1_gnt", 32'(c1_gnt), 32'(eg[1]));
    if (eg[0]) exp_q.push_back({1'b0, mem_fn(a[0])});
    if (eg[1]) exp_q.push_back({1'b1, mem_fn(a[1])});
    gcode = c0_gnt ? 1 : (c1_gnt ? 2 : 0);

    if (m_owner < 0) begin
      if (r[0] && r[1]) m_owner = (m_rr == 1) ? 0 : 1;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
      m_burst = 0;
    end else begin
      x = m_owner;
      y = 1 - x;
      if (!r[x]) begin
        m_burst = 0;
        m_owner = r[y] ? y : -1;
      end else if (mem_ready) begin
        m_rr = x;
        m_burst++;
        if (m_burst == MB) begin
          m_burst = 0;
          if (r[y]) m_owner = y;
        end
      end
    end

    if (c0_gnt) pend[0] = 1'b0;
    if (c1_gnt) pend[1] = 1'b0;
    last_acc  = mem_req && mem_ready;
    last_addr = mem_addr;
  endtask

  task automatic cycle();
    @(negedge clk);
    mem_data = last_acc ? mem_fn(last_addr) : DW'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && (int'($urandom_range(0, 99)) < prob[i])) begin
        pend[i]  = 1'b1;
        paddr[i] = AW'($urandom);
      end
    end
    c0_req  = pend[0];
    c0_addr = paddr[0];
    c1_req  = pend[1];
    c1_addr = paddr[1];
    if (rdy_toggle) begin
      rdy_phase = !rdy_phase;
      mem_ready = rdy_phase;
    end else begin
      mem_ready = int'($urandom_range(0, 99)) < rdy_prob;
    end
    #1;
    eval_cycle();
  endtask

  // monitor: pops one expected beat per rvalid
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      #2;
      chk("rvalid_excl", 32'(c0_rvalid & c1_rvalid), 0);
      if (!c0_rvalid) chk("c0_rdata_idle", 32'(c0_rdata), 0);
      if (!c1_rvalid) chk("c1_rdata_idle", 32'(c1_rdata), 0);
      if (c0_rvalid || c1_rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rvalid_unexpected: got rvalid %0b%0b expected none at %0t",
                   c1_rvalid, c0_rvalid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_client", 32'(c1_rvalid), 32'(e[DW]));
          chk("rdata", 32'(c1_rvalid ? c1_rdata : c0_rdata), 32'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    paddr[0]   = '0;
    paddr[1]   = '0;
    prob[0]    = 0;
    prob[1]    = 0;
    rdy_prob   = 100;
    rdy_toggle = 1'b0;
    rdy_phase  = 1'b0;
    gcode      = 0;
    model_reset();
    do_reset();

    // single client, one bubble from IDLE, one-cycle read latency
    pend[0]  = 1'b1;
    paddr[0] = 14'd129;
    cycle();
    chk("t1_bubble", 32'(gcode), 0);
    cycle();
    chk("t1_gnt", 32'(gcode), 1);
    chk("t1_addr", 32'(mem_addr), 129);
    cycle();
    chk("t1_rvalid", 32'(c0_rvalid), 1);
    chk("t1_rdata", 32'(c0_rdata), 32'(mem_fn(14'd129)));
    repeat (3) cycle();

    // both requesting: bursts of MB alternate with no bubble
    do_reset();
    prob[0] = 100; prob[1] = 100; rdy_prob = 100;
    for (int i = 0; i < 4 * MB + 1; i++) begin
      cycle();
      chk("t2_order", 32'(gcode), (i == 0) ? 0 : ((((i - 1) / MB) % 2 == 0) ? 1 : 2));
    end

    // lone client 1 is never throttled
    do_reset();
    prob[0] = 0; prob[1] = 100;
    for (int i = 0; i < 21; i++) begin
      cycle();
      chk("t3_lone", 32'(gcode), (i == 0) ? 0 : 2);
    end

    // mem_ready toggling: bursts counted in accepts
    do_reset();
    prob[0] = 100; prob[1] = 100;
    rdy_toggle = 1'b1; rdy_phase = 1'b0;
    repeat (48) cycle();
    rdy_toggle = 1'b0;

    // reset mid-burst with a read beat pending
    rdy_prob = 100;
    repeat (4) cycle();
    chk("t5_pre_gnt", 32'(c0_gnt | c1_gnt), 1);
    do_reset();
    cycle();
    chk("t5_bubble", 32'(gcode), 0);
    cycle();
    chk("t5_tie_c0", 32'(gcode), 1);

    // randomised segments
    for (int s = 0; s < 6; s++) begin
      prob[0]  = int'($urandom_range(0, 100));
      prob[1]  = int'($urandom_range(0, 100));
      rdy_prob = int'($urandom_range(20, 100));
      if (s == 3) do_reset();
      repeat (500) cycle();
    end

    // drain
    prob[0] = 0; prob[1] = 0; rdy_prob = 100;
    repeat (8) cycle();
    @(negedge clk);
    #3;
    chk("exp_q_drained", 32'(exp_q.size()), 0);

`ifdef ARB_STAT_EN
    do_reset();
    chk("stat_reset", 32'({c0_acc_cnt, c1_acc_cnt}), 0);
    prob[0] = 100; prob[1] = 0; rdy_prob = 100;
    repeat (70001) cycle();
    chk("stat_sat", 32'(c0_acc_cnt), 32'h0000FFFF);
    chk("stat_gnt_now", 32'(gcode), 1);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    chk("stat_clr", 32'(c0_acc_cnt), 0);
    prob[0] = 0;
    repeat (4) cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
